rbfu_sel_sched: RTL and testbench
=================================

RBFU_SEL_SCHED -- requirements
Module: rbfu_sel_sched

Interface
REQ-001 Parameter P, default 2: number of RBFU lanes; the scheduler drives 2P bank selects.
REQ-002 Parameter MAP, default 2: select width per bank, equal to log2(2P).
REQ-003 Parameter N, default 256: polynomial length; GROUPS = N/(2P) issue slots per stage (64 at defaults).
REQ-004 Parameter STAGES, default 8: number of stages per run.
REQ-005 Parameter GAP, default 2: idle cycles inserted between consecutive stages; range 0..15.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-low.
REQ-008 start  in  1  single-cycle run request; sampled only in IDLE.
REQ-009 en  in  1  downstream ready; 0 stalls issue.
REQ-010 sel_BI_bus  out  2P*MAP  bank-to-lane selects; field b is bits [b*MAP+MAP-1 : b*MAP].
REQ-011 sel_valid  out  1  sel_BI_bus holds a new issue this cycle.
REQ-012 stage_o  out  clog2(STAGES)  stage index of the current issue.
REQ-013 group_o  out  clog2(GROUPS)  group index of the current issue.
REQ-014 busy  out  1  high while in RUN, GAP or DRAIN.
REQ-015 done  out  1  one-cycle pulse at run completion.

Function
REQ-016 FSM states: IDLE, RUN, GAP, DRAIN, DONE; all outputs are registered.
REQ-017 IDLE: start=1 clears the internal counters s and g to 0 and moves to RUN; start=0 stays in IDLE.
REQ-018 RUN with en=1:
  - Next edge sets sel_valid=1, stage_o=s, group_o=g.
  - Each field b of sel_BI_bus becomes (b + s + g) mod 2P.
  - g then increments.
REQ-019 RUN with en=0:
  - Next edge sets sel_valid=0.
  - sel_BI_bus, stage_o, group_o, s and g hold.
REQ-020 Each stage's issue map is a rotation, so it is a permutation; no two banks select the same lane in one issue.
REQ-021 At the last group of a stage (g=GROUPS-1) that issues with s<STAGES-1:
  - g wraps to 0 and s increments.
  - If GAP>0, go to GAP; if GAP=0, stay in RUN.
REQ-022 GAP: sel_valid=0 for exactly GAP cycles, counted by an internal counter; then return to RUN. en has no effect during GAP.
REQ-023 When g=GROUPS-1 and s=STAGES-1 issues, go to DRAIN.
REQ-024 DRAIN: one cycle with sel_valid=0, covering the one-cycle select register at the network input; then go to DONE.
REQ-025 DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
REQ-026 start while not in IDLE is ignored, and no restart is queued.
REQ-027 Outside RUN issue cycles, sel_valid=0 and sel_BI_bus keeps its last value.
REQ-028 Issue count per run is STAGES*GROUPS.
REQ-029 Stall-free run length, start edge to done pulse: STAGES*GROUPS + (STAGES-1)*GAP + 2 cycles (528 at defaults).

Reset
REQ-030 On rst=0, asynchronously and at any time (mid-run included):
  - state=IDLE; s, g and the gap counter are 0.
  - sel_BI_bus=0, sel_valid=0, stage_o=0, group_o=0, busy=0, done=0.
REQ-031 After rst returns to 1, nothing issues until a new start is sampled in IDLE.

Verification
REQ-032 Basic run at defaults: start pulse, en=1 throughout.
  - First issue: sel_valid=1, sel_BI_bus fields {b0..b3} = {0,1,2,3}.
  - Second issue (g=1): fields = {1,2,3,0}.
  - Exactly 512 valid cycles; done pulses 528 cycles after the start edge.
REQ-033 Stage boundary, s=0 to s=1:
  - Issue g=63 is followed by exactly 2 sel_valid=0 cycles.
  - Next issue has stage_o=1, group_o=0, fields {1,2,3,0}.
REQ-034 Stall: en=0 for 5 cycles at g=10 of stage 3.
  - sel_valid=0 for those 5 cycles; outputs hold.
  - Resumes with group_o=10, stage_o=3, no skipped or duplicated group; done is delayed by exactly 5 cycles.
REQ-035 Permutation check: on every valid cycle of a full run, the 4 fields are distinct.
REQ-036 Reset mid-run: rst=0 at stage 4, group 20.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, a start pulse begins again at stage_o=0, group_o=0.
REQ-037 Start while busy: pulse start during RUN.
  - No effect on counters or timing.
  - A start in the cycle after done begins a new run.

Source files
------------

// File: rtl/rbfu_sel_sched.sv
// Bank-to-lane select scheduler for the RBFU network: issues one rotation map per
// group, STAGES stages per run, with idle gaps between stages and a drain cycle at the end.
module rbfu_sel_sched #(
    parameter int P      = 2,
    parameter int MAP    = 2,
    parameter int N      = 256,
    parameter int STAGES = 8,
    parameter int GAP    = 2,
    localparam int BANKS  = 2 * P,
    localparam int GROUPS = N / (2 * P),
    localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1,
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 en,
    output logic [BANKS*MAP-1:0] sel_BI_bus,
    output logic                 sel_valid,
    output logic [SW-1:0]        stage_o,
    output logic [GW-1:0]        group_o,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [SW-1:0] S_LAST   = SW'(STAGES - 1);
    localparam logic [GW-1:0] G_LAST   = GW'(GROUPS - 1);
    localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    state_t        state;
    logic [SW-1:0] s;
    logic [GW-1:0] g;
    logic [3:0]    gap_cnt;

    // BANKS is a power of two (MAP = log2(BANKS)), so the modulo is a plain MAP-bit wrap.
    function automatic logic [BANKS*MAP-1:0] rot_map(input logic [SW-1:0] s_i,
                                                     input logic [GW-1:0] g_i);
        logic [BANKS*MAP-1:0] m;
        logic [MAP-1:0]       base;
        base = MAP'(s_i) + MAP'(g_i);
        for (int b = 0; b < BANKS; b++) begin
            m[b*MAP +: MAP] = MAP'(b) + base;
        end
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            s          <= '0;
            g          <= '0;
            gap_cnt    <= '0;
            sel_BI_bus <= '0;
            sel_valid  <= 1'b0;
            stage_o    <= '0;
            group_o    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            sel_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        s       <= '0;
                        g       <= '0;
                        gap_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        sel_valid  <= 1'b1;
                        stage_o    <= s;
                        group_o    <= g;
                        sel_BI_bus <= rot_map(s, g);
                        if (g == G_LAST) begin
                            g <= '0;
                            if (s == S_LAST) begin
                                state <= ST_DRAIN;
                            end else begin
                                s <= s + 1'b1;
                                if (GAP > 0) begin
                                    gap_cnt <= '0;
                                    state   <= ST_GAP;
                                end
                            end
                        end else begin
                            g <= g + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= ST_RUN;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                // Last selects are still in the network input register for this cycle.
                ST_DRAIN: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rbfu_sel_sched.sv
// Directed bench for rbfu_sel_sched at default parameters: full runs, stage gaps,
// stall, busy-time start, asynchronous mid-run reset.
module tb_rbfu_sel_sched;

    localparam int GAP    = 2;
    localparam int GROUPS = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       en;
    logic [7:0] sel_BI_bus;
    logic       sel_valid;
    logic [2:0] stage_o;
    logic [5:0] group_o;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    rbfu_sel_sched dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .en         (en),
        .sel_BI_bus (sel_BI_bus),
        .sel_valid  (sel_valid),
        .stage_o    (stage_o),
        .group_o    (group_o),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_bus(input int s, input int g);
        logic [7:0] v;
        for (int b = 0; b < 4; b++) v[b*2 +: 2] = 2'((b + s + g) % 4);
        return v;
    endfunction

    function automatic logic distinct(input logic [7:0] v);
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (v[i*2 +: 2] == v[j*2 +: 2]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_run(input int stall_len, input bit mid_start,
                          output int done_cyc, output int nvalid);
        int cyc;
        int es;
        int eg;
        int idle_run;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        es = 0; eg = 0; cyc = 0; nvalid = 0; idle_run = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < 2000) begin
            tick();
            cyc++;
            if (mid_start) start = (cyc == 100);
            if (sel_valid) begin
                nvalid++;
                if (eg == 0 && es > 0) chk("stage_gap", idle_run, GAP);
                if (nvalid == 1) chk("first_issue", sel_BI_bus, 8'hE4);
                if (nvalid == 2) chk("second_issue", sel_BI_bus, 8'h39);
                if (es == 1 && eg == 0) chk("s1_first_issue", {stage_o, group_o, sel_BI_bus}, {3'd1, 6'd0, 8'h39});
                chk("stage_o", stage_o, es);
                chk("group_o", group_o, eg);
                chk("sel_bus", sel_BI_bus, exp_bus(es, eg));
                chk("perm", distinct(sel_BI_bus), 1);
                idle_run = 0;
                if (stall_len > 0 && es == 3 && eg == 9) begin
                    en = 1'b0;
                    for (int k = 0; k < stall_len; k++) begin
                        tick();
                        cyc++;
                        chk("stall_valid", sel_valid, 0);
                        chk("stall_hold", {stage_o, group_o, sel_BI_bus}, {3'd3, 6'd9, exp_bus(3, 9)});
                    end
                    en = 1'b1;
                end
                if (eg == GROUPS - 1) begin
                    eg = 0;
                    es++;
                end else begin
                    eg++;
                end
            end else begin
                idle_run++;
                if (done) done_cyc = cyc;
            end
        end
        start = 1'b0;
        if (done_cyc < 0) chk("done_timeout", 0, 1);
        chk("busy_at_done", busy, 0);
        tick();
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        int dc;
        int nv;
        int wait_cyc;
        rst   = 1'b0;
        start = 1'b0;
        en    = 1'b1;
        repeat (3) tick();
        chk("rst_sel_bus", sel_BI_bus, 0);
        chk("rst_valid", sel_valid, 0);
        chk("rst_stage", stage_o, 0);
        chk("rst_group", group_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        repeat (3) tick();
        chk("idle_no_issue", sel_valid, 0);
        chk("idle_not_busy", busy, 0);

        // Plain run.
        do_run(0, 1'b0, dc, nv);
        chk("run1_valid_count", nv, 512);
        chk("run1_done_cycle", dc, 528);

        // Stall plus ignored start, begun right after the previous done.
        do_run(5, 1'b1, dc, nv);
        chk("run2_valid_count", nv, 512);
        chk("run2_done_cycle", dc, 533);

        // Asynchronous reset in the middle of stage 4.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_cyc = 0;
        while (!(sel_valid && stage_o == 3'd4 && group_o == 6'd20) && wait_cyc < 1000) begin
            tick();
            wait_cyc++;
        end
        chk("reach_s4_g20", wait_cyc < 1000, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_sel_bus", sel_BI_bus, 0);
        chk("arst_valid", sel_valid, 0);
        chk("arst_stage", stage_o, 0);
        chk("arst_group", group_o, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("post_rst_no_issue", sel_valid, 0);
        chk("post_rst_idle", busy, 0);

        do_run(0, 1'b0, dc, nv);
        chk("run3_valid_count", nv, 512);
        chk("run3_done_cycle", dc, 528);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
